// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST: op codes and FSM state encoding.
package gate_bist_pkg;

    localparam logic [2:0] OP_BUF  = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate_bist_if.sv
// Control/status bundle of the gate BIST. The fail_vec signal exists only
// when GATE_BIST_FIRST_FAIL_EN is defined.
interface gate_bist_if #(
    parameter int WIDTH = 1
);
    logic                 start;
    logic [2:0]           op;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH:0]     err_cnt;
`ifdef GATE_BIST_FIRST_FAIL_EN
    logic [2*WIDTH-1:0]   fail_vec;

    modport master (output start, op, input busy, done, pass, err_cnt, fail_vec);
    modport slave  (input start, op, output busy, done, pass, err_cnt, fail_vec);
`else
    modport master (output start, op, input busy, done, pass, err_cnt);
    modport slave  (input start, op, output busy, done, pass, err_cnt);
`endif
endinterface

// File: rtl/gate_ref.sv
// Purely combinational reference model of the gates under test.
module gate_ref
    import gate_bist_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Bitwise gate function selected by op; b is ignored for BUF/NOT.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_BUF:  y = a;
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/gate_bist.sv
// Built-in self-test for a combinational gate: sweeps every {a,b} vector,
// holds each for SETTLE cycles, samples the gate output and counts
// mismatches against gate_ref. Defining GATE_BIST_FIRST_FAIL_EN adds the
// fail_vec output holding the first failing {a,b} of a run.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    gate_bist_if.slave       bus,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_y
);

    localparam int         VW        = 2 * WIDTH;
    localparam int         EW        = 2 * WIDTH + 1;
    localparam logic [VW-1:0] V_LAST = {VW{1'b1}};
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t          state_r;
    logic [2:0]      op_r;
    logic [VW-1:0]   v_r;
    logic [3:0]      cnt_r;
    logic [EW-1:0]   err_cnt_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
`ifdef GATE_BIST_FIRST_FAIL_EN
    logic [VW-1:0]   fail_vec_r;
`endif

    logic [WIDTH-1:0] ref_y_s;
    logic             mismatch_s;
    logic [EW-1:0]    err_next_s;

    gate_ref #(.WIDTH(WIDTH)) u_ref (
        .op (op_r),
        .a  (v_r[VW-1:WIDTH]),
        .b  (v_r[WIDTH-1:0]),
        .y  (ref_y_s)
    );

    // Compare the gate output with the model and form the next error count.
    always_comb begin
        mismatch_s = 1'b0;
        err_next_s = err_cnt_r;
        if (dut_y != ref_y_s) begin
            mismatch_s = 1'b1;
            err_next_s = err_cnt_r + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            mismatch_s = 1'b0;
            err_next_s = err_cnt_r;
        end
    end

    // Sequencing FSM: vector sweep, settle timing, error counting and verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            op_r       <= 3'd0;
            v_r        <= {VW{1'b0}};
            cnt_r      <= 4'd0;
            err_cnt_r  <= {EW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
`ifdef GATE_BIST_FIRST_FAIL_EN
            fail_vec_r <= {VW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // A new run starts identically from IDLE or DONE.
                    if (bus.start) begin
                        state_r    <= DRIVE;
                        op_r       <= bus.op;
                        v_r        <= {VW{1'b0}};
                        cnt_r      <= 4'd0;
                        err_cnt_r  <= {EW{1'b0}};
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
`ifdef GATE_BIST_FIRST_FAIL_EN
                        fail_vec_r <= {VW{1'b0}};
`endif
                    end
                end
                DRIVE: begin
                    if (cnt_r == SETTLE_M1) begin
                        cnt_r   <= 4'd0;
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                SAMPLE: begin
                    err_cnt_r <= err_next_s;
`ifdef GATE_BIST_FIRST_FAIL_EN
                    // Only the first mismatch of the run is recorded.
                    if (mismatch_s && (err_cnt_r == {EW{1'b0}})) begin
                        fail_vec_r <= v_r;
                    end
`endif
                    if (v_r == V_LAST) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == {EW{1'b0}});
                    end else begin
                        v_r     <= v_r + {{(VW-1){1'b0}}, 1'b1};
                        state_r <= DRIVE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dut_a       = v_r[VW-1:WIDTH];
    assign dut_b       = v_r[WIDTH-1:0];
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.err_cnt = err_cnt_r;
`ifdef GATE_BIST_FIRST_FAIL_EN
    assign bus.fail_vec = fail_vec_r;
`endif

endmodule

// File: doc/gate_bist.md
# gate_bist

Hardware built-in self-test for the combinational gates in `portas/`. It exhaustively drives every input combination into a gate under test, waits for the outputs to settle, and compares the gate's output against an internal reference model. It reports a pass/fail verdict and an error count. It is the synthesizable counterpart of the per-gate testbenches: the block generates stimulus and checks responses in the fabric instead of in simulation.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of each gate operand, legal range 1..4.
- `SETTLE`, default 1: cycles each vector is held before sampling, legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a test run.
- `op`  in  3: expected gate function, sampled when `start` is accepted.
- `dut_a`  out  WIDTH: stimulus operand a.
- `dut_b`  out  WIDTH: stimulus operand b.
- `dut_y`  in  WIDTH: gate-under-test output.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished; verdict is valid.
- `pass`  out  1: `done` and zero mismatches.
- `err_cnt`  out  2*WIDTH+1: number of mismatching vectors.
- `fail_vec`  out  2*WIDTH: first failing {a,b}. Present only with the macro enabled.

## Operation
- Op codes: 0 BUF(a), 1 NOT(a), 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR. All operations are bitwise over WIDTH bits.
- Vector index `v` runs 0..2^(2*WIDTH)-1, with {dut_a,dut_b} = v (a holds the upper bits). For BUF and NOT, b is still swept and is ignored by the model.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE: outputs are zeroed. When `start` is asserted, latch `op`, clear `err_cnt` to 0 and `v` to 0, then go to DRIVE.
  - DRIVE: hold `v` for SETTLE cycles, then go to SAMPLE.
  - SAMPLE: compare `dut_y` against `ref(op,a,b)`. If any bit differs, increment `err_cnt`. If `v` is the last vector, go to DONE; otherwise increment `v` and go to DRIVE.
  - DONE: `done`=1, `pass`=(err_cnt==0), and `dut_a`/`dut_b` hold the last vector. When `start` is asserted, begin a new run exactly as from IDLE.
- `busy` = state is DRIVE or SAMPLE.
- `start` is ignored while `busy` is high. Changes on `op` during a run are ignored.
- `err_cnt` cannot overflow, because its width covers 2^(2W) mismatches. `v` does not wrap back to 0 inside a run.
- When `rst` is asserted at any time, including mid-run, the block asynchronously returns to IDLE with all outputs at 0. No partial verdict is reported.

## Timing
- Reset values: `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0.
- Taking the cycle that `start` is sampled as cycle 0:
  - Vector 0 appears on `dut_a`/`dut_b` and `busy` rises at cycle 1.
  - Each vector occupies SETTLE+1 cycles.
  - `done` rises at cycle 1 + 2^(2W)·(SETTLE+1).
- `dut_y` is sampled in the last cycle a vector is held. The comparison is combinational and the counter is registered. The gate path must settle within SETTLE clock periods.
- All outputs are registered.

## Configuration
- `GATE_BIST_FIRST_FAIL_EN` defined:
  - The `fail_vec` port exists.
  - It captures {a,b} of the first mismatch in a run and holds that value until the next `start` or reset.
  - It stays 0 if no mismatch occurs.
- Undefined: the `fail_vec` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `gate_bist_pkg` holds:
  - The op code constants (OP_BUF..OP_XNOR).
  - The FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3).
- Sub-module `gate_ref` is the purely combinational reference model: (op, a, b) → y, WIDTH-parameterized. It is instantiated once.

## Test plan
- WIDTH=1, SETTLE=1, op=1, `dut_y` wired to a correct `gnot(dut_a)` → `done` at cycle 9, `pass`=1, `err_cnt`=0.
- WIDTH=1, op=2, `dut_y` wired to OR instead of AND → `err_cnt`=2 (vectors 01 and 10), `pass`=0, `fail_vec`=2'b01 with the macro enabled.
- WIDTH=2, SETTLE=3, op=6 with a correct XOR → 16 vectors, `done` at cycle 65, `pass`=1.
- WIDTH=1, `dut_y` stuck at 1, op=4 (NAND) → `err_cnt`=1 (vector 11), `pass`=0.
- Assert `rst` at cycle 4 of a run → all outputs 0 immediately. A `start` at cycle 6 then completes a normal run with `done` at cycle 15.
- `start` pulsed while `busy`, and `op` changed mid-run → no restart; the verdict reflects the originally latched `op`.
